imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder for the fetch stage.
- Sits opposite the program counter: accepts fetch requests carrying a PC address and returns the addressed 32-bit instruction after a fixed, configurable latency.
- Both request and response sides use valid/ready handshakes, so the PC stalls naturally while a fetch is outstanding.
- A side-band load port preloads program words for benches and bring-up.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit instruction words; must be a power of 2.
- LATENCY, 2: cycles from request acceptance to resp_valid; legal range 1..15.
- NOP_WORD, 32'h00000013: instruction returned on an error response (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (clk and reset named as elsewhere in the fetch path; reset=0 clears state immediately).
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address from PC.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  response word valid.
- resp_ready  in  1  fetch/decode consumer accepts response.
- resp_instr  out  32  instruction word.
- resp_addr  out  32  address the response belongs to.
- resp_err  out  1  misaligned or out-of-range request.
- load_en  in  1  write one program word.
- load_addr  in  32  byte address of load (word index = load_addr[log2(DEPTH)+1:2]).
- load_data  in  32  word to write.

Behaviour:
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: latency countdown.
  - RESP: response held.
- Combinational outputs:
  - req_ready = (state==IDLE) | (state==RESP & resp_ready).
  - resp_valid = (state==RESP).
- Request accept (req_valid & req_ready):
  - Capture req_addr into addr_q.
  - Load cnt = LATENCY-1.
  - Go to WAIT.
- WAIT: if cnt==0, go to RESP and register resp_instr, resp_err and resp_addr=addr_q on that edge; else cnt decrements.
- Response timing: resp_valid rises exactly LATENCY rising edges after the accepting edge.
- RESP: outputs hold stable while resp_ready=0. On resp_ready=1:
  - With req_valid=1, accept the new request in the same cycle and go to WAIT (back-to-back).
  - Otherwise go to IDLE.
  - Sustained throughput is therefore one word per LATENCY+1 cycles.
- Error rules:
  - addr_q[1:0]!=0 → resp_err=1, resp_instr=NOP_WORD.
  - addr_q >= 4*DEPTH_WORDS → resp_err=1, resp_instr=NOP_WORD.
  - Otherwise resp_err=0 and resp_instr=mem[addr_q[log2(DEPTH)+1:2]].
- Load port:
  - load_en writes mem on the rising edge in any state.
  - Out-of-range or misaligned load addresses are ignored (no write).
  - A load to the same word on the edge that samples the read returns the OLD data (read-before-write).
  - A load during WAIT to the pending word, before the sampling edge, is visible in the response.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, resp_instr=0, resp_addr=0, resp_err=0.
  - resp_valid=0 immediately; any outstanding request is discarded and no response is issued.
  - Memory contents are not reset.
- After reset deassertion, req_ready=1 on the first cycle.
- req_addr is ignored unless the request is accepted; changing it in WAIT/RESP has no effect.

Decomposition:
- Shared fetch package holds:
  - XLEN=32.
  - NOP constant 32'h00000013.
  - FSM state typedef (IDLE/WAIT/RESP, 2 bits).
- One natural sub-module: imem_array (synchronous write, combinational read, DEPTH_WORDS x 32). It is instantiated once; the FSM, counter and error logic stay in imem_responder.

Test Plan:
- Reset, then load words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013. With LATENCY=2, request 0x0 accepted at edge N → resp_valid=1 after edge N+2, resp_instr=32'h00500093, resp_addr=0, resp_err=0.
- Hold resp_ready=0 for 5 cycles on request 0x4 → resp_valid, resp_instr=32'h00A00113 and req_ready=0 stable throughout; raise resp_ready with req_valid=1, addr 0x8 → same-cycle accept, next response 32'h002081B3 two edges later.
- Request 0x6 (misaligned) and 0x400 (DEPTH=256, out of range) → resp_err=1, resp_instr=32'h00000013, resp_addr echoes 0x6 / 0x400.
- Request 0xC accepted, then drive reset=0 mid-WAIT → resp_valid and resp_err drop immediately, resp_instr=0. After release, no stale response appears and req_ready=1; memory still returns 32'h00000013 at 0xC.
- Load 0x0=32'hDEADBEEF on the edge that samples a pending read of 0x0 → response is 32'h00500093. A following read of 0x0 → 32'hDEADBEEF.
- LATENCY=1 build, continuous req_valid with resp_ready=1 over 0x0,0x4,0x8 → one response every 2 cycles, in order, correct addresses.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared fetch-path definitions: data width, the canonical NOP, responder FSM
// encoding and the word-address legality check used by both read and load paths.
package imem_responder_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // A byte address names a real word only if it is word aligned and below the array end.
  function automatic logic word_addr_ok(input logic [XLEN-1:0] addr,
                                        input int unsigned   depth_words);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < XLEN'(depth_words));
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake plus the side-band program-load port.
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_instr;
  logic [XLEN-1:0] resp_addr;
  logic            resp_err;
  logic            load_en;
  logic [XLEN-1:0] load_addr;
  logic [XLEN-1:0] load_data;

  modport slave (
    input  req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
    output req_ready, resp_valid, resp_instr, resp_addr, resp_err
  );

  modport master (
    output req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
    input  req_ready, resp_valid, resp_instr, resp_addr, resp_err
  );

endinterface

// File: rtl/imem_responder_array.sv
// Instruction storage: synchronous write, combinational read, so a read sampled on
// the same edge as a write to that word sees the old contents.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  // NOTE: storage has no reset; program contents survive a fetch-path reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: accepts one PC request at a time and
// returns the addressed word LATENCY edges later, holding it until consumed.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int              DEPTH_WORDS = 256,
  parameter int              LATENCY     = 2,
  parameter logic [XLEN-1:0] NOP_WORD    = NOP_INSTR
) (
  input logic              clk,
  input logic              reset,
  imem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] resp_addr_q, resp_addr_d;
  logic            err_q, err_d;

  logic            req_ready;
  logic            accept;
  logic            load_ok;
  logic            read_ok;
  logic [XLEN-1:0] rd_word;

  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.resp_ready);
  assign accept    = bus.req_valid && req_ready;
  assign load_ok   = bus.load_en && word_addr_ok(bus.load_addr, DEPTH_WORDS);
  assign read_ok   = word_addr_ok(addr_q, DEPTH_WORDS);

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (load_ok),
    .waddr (bus.load_addr[AW+1:2]),
    .wdata (bus.load_data),
    .raddr (addr_q[AW+1:2]),
    .rdata (rd_word)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    resp_addr_d = resp_addr_q;
    err_d       = err_q;

    // accept is only possible from IDLE, or from RESP as the held word is consumed
    if (accept) begin
      addr_d  = bus.req_addr;
      cnt_d   = 4'(LATENCY - 1);
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d     = ST_RESP;
            resp_addr_d = addr_q;
            err_d       = !read_ok;
            instr_d     = read_ok ? rd_word : NOP_WORD;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      instr_q     <= '0;
      resp_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      resp_addr_q <= resp_addr_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_instr = instr_q;
  assign bus.resp_addr  = resp_addr_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=2 and a LATENCY=1 instance checked against
// a word-array reference model with directed and randomized fetch/load traffic.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT2  = 2;
  localparam int LAT1  = 1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [32:0] last_exp;
  logic [31:0] last_addr;

  imem_responder_if b2 ();
  imem_responder_if b1 ();

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave));
  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what a fetch of byte address a returns, as {err, instr}.
  function automatic logic [32:0] model_rd(input logic [31:0] a);
    if ((a % 4) != 0 || a >= 32'(DEPTH * 4)) return {1'b1, NOP_INSTR};
    return {1'b0, model_mem[a / 4]};
  endfunction

  function automatic void model_load(input logic [31:0] a, input logic [31:0] d);
    if ((a % 4) == 0 && a < 32'(DEPTH * 4)) model_mem[a / 4] = d;
  endfunction

  task automatic set_load(input logic en, input logic [31:0] a, input logic [31:0] d);
    b2.load_en = en; b2.load_addr = a; b2.load_data = d;
    b1.load_en = en; b1.load_addr = a; b1.load_data = d;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    set_load(1'b1, a, d);
    tick();
    model_load(a, d);
    set_load(1'b0, 32'h0, 32'h0);
  endtask

  // Fetch on the LATENCY=2 instance; optionally load a word on edge ld_at after accept.
  task automatic issue(input logic [31:0] a, input int ld_at,
                       input logic [31:0] ld_a, input logic [31:0] ld_d);
    b2.req_valid = 1'b1;
    b2.req_addr  = a;
    #1;
    check("req_ready_at_issue", 64'(b2.req_ready), 64'd1);
    tick();
    b2.req_valid  = 1'b0;
    b2.req_addr   = $urandom;
    b2.resp_ready = 1'b0;
    check("resp_valid_after_accept", 64'(b2.resp_valid), 64'd0);
    for (int i = 1; i <= LAT2; i++) begin
      if (i == ld_at) set_load(1'b1, ld_a, ld_d);
      if (i == LAT2) last_exp = model_rd(a);
      tick();
      if (i == ld_at) begin
        model_load(ld_a, ld_d);
        set_load(1'b0, 32'h0, 32'h0);
      end
      check("resp_valid_timing", 64'(b2.resp_valid), 64'(i == LAT2));
    end
    last_addr = a;
    check("resp_instr", 64'(b2.resp_instr), 64'(last_exp[31:0]));
    check("resp_addr", 64'(b2.resp_addr), 64'(a));
    check("resp_err", 64'(b2.resp_err), 64'(last_exp[32]));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("hold_valid", 64'(b2.resp_valid), 64'd1);
      check("hold_instr", 64'(b2.resp_instr), 64'(last_exp[31:0]));
      check("hold_addr", 64'(b2.resp_addr), 64'(last_addr));
      check("hold_req_ready", 64'(b2.req_ready), 64'd0);
    end
  endtask

  task automatic release_resp();
    b2.resp_ready = 1'b1;
    #1;
    check("req_ready_on_consume", 64'(b2.req_ready), 64'd1);
    tick();
    b2.resp_ready = 1'b0;
    check("resp_valid_after_consume", 64'(b2.resp_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] a, ld_a;
    int          sel, ld_at;
    logic [31:0] stream [3];

    reset = 1'b0;
    b2.req_valid = 1'b0; b2.req_addr = 32'h0; b2.resp_ready = 1'b0;
    b1.req_valid = 1'b0; b1.req_addr = 32'h0; b1.resp_ready = 1'b0;
    set_load(1'b0, 32'h0, 32'h0);

    repeat (3) tick();
    check("rst_resp_valid", 64'(b2.resp_valid), 64'd0);
    check("rst_resp_instr", 64'(b2.resp_instr), 64'd0);
    check("rst_resp_addr", 64'(b2.resp_addr), 64'd0);
    check("rst_resp_err", 64'(b2.resp_err), 64'd0);
    check("rst_l1_resp_valid", 64'(b1.resp_valid), 64'd0);
    reset = 1'b1;
    #1;
    check("post_rst_req_ready", 64'(b2.req_ready), 64'd1);
    check("post_rst_l1_req_ready", 64'(b1.req_ready), 64'd1);

    // Preload everything, then the program words, then loads that must be ignored.
    for (int w = 0; w < DEPTH; w++) load_word(32'(w * 4), $urandom);
    load_word(32'h0, 32'h0050_0093);
    load_word(32'h4, 32'h00A0_0113);
    load_word(32'h8, 32'h0020_81B3);
    load_word(32'hC, 32'h0000_0013);
    load_word(32'h400, 32'hBAD0_BAD0);
    load_word(32'h5, 32'hBAD1_BAD1);

    // Basic fetch and latency.
    issue(32'h0, 0, 32'h0, 32'h0);
    check("word0", 64'(b2.resp_instr), 64'h0050_0093);
    release_resp();

    // Back-pressure, then back-to-back accept as the held word is consumed.
    issue(32'h4, 0, 32'h0, 32'h0);
    hold(5);
    b2.resp_ready = 1'b1;
    issue(32'h8, 0, 32'h0, 32'h0);
    check("word2_b2b", 64'(b2.resp_instr), 64'h0020_81B3);
    release_resp();

    // Error responses.
    issue(32'h6, 0, 32'h0, 32'h0);
    check("misaligned_err", 64'({b2.resp_err, b2.resp_instr}), 64'h1_0000_0013);
    release_resp();
    issue(32'h400, 0, 32'h0, 32'h0);
    check("range_err", 64'({b2.resp_err, b2.resp_instr}), 64'h1_0000_0013);
    check("range_addr", 64'(b2.resp_addr), 64'h400);
    release_resp();

    // Load on the sampling edge is not seen; a load earlier in the wait is.
    issue(32'h0, LAT2, 32'h0, 32'hDEAD_BEEF);
    check("rbw_old", 64'(b2.resp_instr), 64'h0050_0093);
    release_resp();
    issue(32'h0, 0, 32'h0, 32'h0);
    check("rbw_new", 64'(b2.resp_instr), 64'hDEAD_BEEF);
    release_resp();
    issue(32'h10, 1, 32'h10, 32'h1234_5678);
    check("wait_load_visible", 64'(b2.resp_instr), 64'h1234_5678);
    release_resp();

    // Randomized fetches with loads landing at random points of the wait.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel < 9) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else              a = 32'(DEPTH * 4 + $urandom_range(0, 4096));
      ld_at = $urandom_range(0, LAT2);
      ld_a  = ($urandom_range(0, 1) == 1) ? {a[31:2], 2'b00}
                                          : 32'($urandom_range(0, DEPTH * 4 + 64));
      issue(a, ld_at, ld_a, $urandom);
      hold($urandom_range(0, 3));
      release_resp();
    end

    // Asynchronous reset in the middle of a wait discards the request.
    b2.req_valid = 1'b1;
    b2.req_addr  = 32'hC;
    tick();
    b2.req_valid = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("midwait_rst_valid", 64'(b2.resp_valid), 64'd0);
    check("midwait_rst_err", 64'(b2.resp_err), 64'd0);
    check("midwait_rst_instr", 64'(b2.resp_instr), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale_resp", 64'(b2.resp_valid), 64'd0);
      check("idle_req_ready", 64'(b2.req_ready), 64'd1);
    end
    issue(32'hC, 0, 32'h0, 32'h0);
    check("mem_survives_reset", 64'(b2.resp_instr), 64'h0000_0013);
    release_resp();

    // LATENCY=1 streaming: one response every two cycles, in order.
    stream[0] = 32'h0; stream[1] = 32'h4; stream[2] = 32'h8;
    b1.resp_ready = 1'b1;
    b1.req_valid  = 1'b1;
    b1.req_addr   = stream[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      check("l1_wait_valid", 64'(b1.resp_valid), 64'd0);
      if (k < 2) b1.req_addr = stream[k + 1];
      else       b1.req_valid = 1'b0;
      last_exp = model_rd(stream[k]);
      tick();
      check("l1_resp_valid", 64'(b1.resp_valid), 64'd1);
      check("l1_resp_addr", 64'(b1.resp_addr), 64'(stream[k]));
      check("l1_resp_instr", 64'(b1.resp_instr), 64'(last_exp[31:0]));
      check("l1_resp_err", 64'(b1.resp_err), 64'(last_exp[32]));
    end
    tick();
    check("l1_idle_after_stream", 64'(b1.resp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
